// File: rtl/dii_package.sv
`default_nettype none
// ============================================================================
// Package     : dii_package
// Description : Debug-interconnect (DII) flit type and the packet arbiter
//               state encoding shared by the ring expander blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package dii_package;

  // One DII flit: handshake valid, end-of-packet marker and 16-bit payload.
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  // Packet arbiter states: IDLE arbitrates, BUSY forwards the owner's packet.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dii_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/osd_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : osd_rr_select
// Description : Combinational round-robin picker. Selects the first asserted
//               request searching upward from last+1 (modulo PORTS) and
//               returns it one-hot together with a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module osd_rr_select #(
  parameter int PORTS = 2
) (
  input  logic [PORTS-1:0]         req,
  input  logic [$clog2(PORTS)-1:0] last,
  output logic [PORTS-1:0]         sel,
  output logic                     valid
);

  int w_dist;
  int w_best;

  // Rank every requester by its distance from last+1; the nearest one wins.
  always_comb begin
    sel    = '0;
    valid  = |req;
    w_dist = 0;
    w_best = PORTS;
    for (int i = 0; i < PORTS; i++) begin
      // 2*PORTS keeps the dividend positive even for an out-of-range last.
      w_dist = (i + 2 * PORTS - int'(last) - 1) % PORTS;
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
      end
    end
    for (int i = 0; i < PORTS; i++) begin
      w_dist = (i + 2 * PORTS - int'(last) - 1) % PORTS;
      sel[i] = req[i] && (w_dist == w_best);
    end
  end

endmodule
`default_nettype wire

// File: rtl/osd_dii_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : osd_dii_packet_arbiter
// Description : Packet-granular round-robin arbiter merging PORTS DII flit
//               sources onto one egress. A grant is held until the owner's
//               last flit is accepted; every packet costs one IDLE bubble.
//               Optional length check: define OSD_DII_ARB_PKT_LEN_CHECK_EN to
//               cut packets at MAX_PKT_LEN flits and flag err_oversize.
// Revision    : 1.0 - initial release
// ============================================================================
module osd_dii_packet_arbiter
  import dii_package::*;
#(
  parameter int PORTS       = 2,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  dii_flit [PORTS-1:0]   in_flit,
  output logic    [PORTS-1:0]   in_ready,
  output dii_flit               out_flit,
  input  logic                  out_ready,
  output logic    [PORTS-1:0]   grant,
  output logic                  busy,
  output logic                  err_oversize
);

  localparam int LW = $clog2(PORTS);

  dii_arb_state_t   state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [LW-1:0]    last_grant_q, last_grant_d;

  logic [PORTS-1:0] w_req;
  logic [PORTS-1:0] w_rr_sel;
  logic             w_rr_valid;
  dii_flit          w_owner;
  logic [LW-1:0]    w_owner_idx;
  logic             w_xfer;
  logic             w_force_last;
  logic             w_eff_last;

  // Gather the request vector and select the owner's flit by its one-hot grant.
  always_comb begin
    w_req       = '0;
    w_owner     = '0;
    w_owner_idx = '0;
    for (int i = 0; i < PORTS; i++) begin
      w_req[i] = in_flit[i].valid;
      if (grant_q[i]) begin
        w_owner     = in_flit[i];
        w_owner_idx = LW'(i);
      end
    end
  end

  osd_rr_select #(
    .PORTS (PORTS)
  ) u_rr_select (
    .req   (w_req),
    .last  (last_grant_q),
    .sel   (w_rr_sel),
    .valid (w_rr_valid)
  );

  assign busy       = (state_q == BUSY);
  assign grant      = grant_q;
  assign w_xfer     = busy && w_owner.valid && out_ready;
  assign w_eff_last = w_owner.last || w_force_last;
  assign in_ready   = busy ? (grant_q & {PORTS{out_ready}}) : '0;

  // Forward the owner's flit while BUSY; the length check may force last.
  always_comb begin
    out_flit = '0;
    if (busy) begin
      out_flit      = w_owner;
      out_flit.last = w_eff_last;
    end
  end

`ifdef OSD_DII_ARB_PKT_LEN_CHECK_EN
  localparam int CW = $clog2(MAX_PKT_LEN + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // The flit being offered is number cnt_q+1; cut the packet at MAX_PKT_LEN.
  assign w_force_last = (cnt_q == CW'(MAX_PKT_LEN - 1)) && !w_owner.last;
  assign err_oversize = err_q;

  // Count transfers of the current grant and latch the sticky oversize flag.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (w_xfer) begin
      cnt_d = cnt_q + 1'b1;
      if (w_force_last) begin
        err_d = 1'b1;
      end
    end
  end

  // Counter and error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  // Length check not built: last passes through and no error is reported.
  logic unused_max_pkt_len;
  assign unused_max_pkt_len = (MAX_PKT_LEN > 0);
  assign w_force_last       = 1'b0;
  assign err_oversize       = 1'b0;
`endif

  // Next state: grant from IDLE, release after the owner's last transfer.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (w_rr_valid) begin
          grant_d = w_rr_sel;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (w_xfer && w_eff_last) begin
          grant_d      = '0;
          last_grant_d = w_owner_idx;
          state_d      = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; last_grant resets to PORTS-1 so port 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LW'(PORTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
`default_nettype wire
